// File: rtl/key_scan_encoder_if.sv
// Key code handshake between the scan encoder and the tone logic.
// The master presents a code and its overrun flag; the slave accepts it.
interface key_scan_encoder_if;
   logic [2:0] key_code;
   logic       key_valid;
   logic       key_ready;
   logic       overrun;

   modport master (
      output key_code,
      output key_valid,
      output overrun,
      input  key_ready
   );

   modport slave (
      input  key_code,
      input  key_valid,
      input  overrun,
      output key_ready
   );
endinterface

// File: rtl/key_scan_encoder.sv
// Key front end: two-flop sync, debounce, priority encode, and announce
// each new key code over a valid/ready handshake with overrun detection.
module key_scan_encoder #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic [6:0]           raw_keys,
   output logic [6:0]           keys_db,
   key_scan_encoder_if.master   bus
);

   typedef enum logic {IDLE, PEND} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [6:0]       s1_q, s2_q;
   logic [6:0]       cand_q, cand_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [6:0]       db_q, db_d;
   logic [2:0]       code_q, code_d;
   logic             ovr_q, ovr_d;
   state_t           state_q, state_d;

   logic       commit;
   logic       code_chg;
   logic [2:0] cand_code;

   function automatic logic [2:0] enc(input logic [6:0] k);
      logic [2:0] c;
      c = '0;
      for (int i = 0; i < 7; i++)
         if (k[i]) c = 3'(i + 1);
      return c;
   endfunction

   assign cand_code = enc(cand_q);
   assign commit    = (s2_q == cand_q) && (cnt_q == CNT_MAX) &&
                      (cand_q != db_q);
   assign code_chg  = commit && (cand_code != code_q);

   always_comb begin
      cand_d = cand_q;
      cnt_d  = cnt_q;
      db_d   = db_q;
      code_d = code_q;
      if (s2_q != cand_q) begin
         cand_d = s2_q;
         cnt_d  = '0;
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + 1'b1;
      end else if (commit) begin
         db_d   = cand_q;
         code_d = cand_code;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         s1_q   <= '0;
         s2_q   <= '0;
         cand_q <= '0;
         cnt_q  <= '0;
         db_q   <= '0;
         code_q <= '0;
         ovr_q  <= 1'b0;
      end else begin
         s1_q   <= raw_keys;
         s2_q   <= s1_q;
         cand_q <= cand_d;
         cnt_q  <= cnt_d;
         db_q   <= db_d;
         code_q <= code_d;
         ovr_q  <= ovr_d;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // A fresh code always wins over a same-cycle acceptance.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (code_chg) state_d = PEND;
         PEND: begin
            if (code_chg)           state_d = PEND;
            else if (bus.key_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ovr_d         = code_chg && (state_q == PEND) && !bus.key_ready;
      bus.key_valid = (state_q == PEND);
      bus.key_code  = code_q;
      bus.overrun   = ovr_q;
      keys_db       = db_q;
   end

endmodule

// File: tb/tb_key_scan_encoder.sv
// Directed bench for key_scan_encoder: DEBOUNCE_CYCLES=4 and 1 instances.
// Expected values are hand-computed from the debounce/encode timing.
module tb_key_scan_encoder;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic [6:0] raw_keys = '0;
   logic [6:0] keys_db, keys_db1;
   int         n_chk = 0;
   int         n_err = 0;

   key_scan_encoder_if kif ();
   key_scan_encoder_if kif1 ();

   key_scan_encoder #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
      .clk      (clk),
      .resetn   (resetn),
      .raw_keys (raw_keys),
      .keys_db  (keys_db),
      .bus      (kif)
   );

   key_scan_encoder #(.DEBOUNCE_CYCLES(1), .CNT_W(3)) dut1 (
      .clk      (clk),
      .resetn   (resetn),
      .raw_keys (raw_keys),
      .keys_db  (keys_db1),
      .bus      (kif1)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic accept();
      kif.key_ready = 1'b1;
      tick();
      kif.key_ready = 1'b0;
   endtask

   task automatic settle(input logic [6:0] v);
      raw_keys = v;
      tick(7);
   endtask

   initial begin
      kif.key_ready  = 1'b0;
      kif1.key_ready = 1'b0;
      tick(2);
      check("rst_db", 32'(keys_db), 32'h0);
      check("rst_code", 32'(kif.key_code), 32'h0);
      check("rst_valid", 32'(kif.key_valid), 32'h0);
      check("rst_ovr", 32'(kif.overrun), 32'h0);

      // 1: reset mid-run, then single key latency on both instances
      resetn = 1'b1;
      settle(7'b0000001);
      check("pre_code", 32'(kif.key_code), 32'h1);
      #2 resetn = 1'b0;
      #1;
      check("arst_db", 32'(keys_db), 32'h0);
      check("arst_code", 32'(kif.key_code), 32'h0);
      check("arst_valid", 32'(kif.key_valid), 32'h0);
      check("arst_code1", 32'(kif1.key_code), 32'h0);
      raw_keys = 7'b0000100;
      tick();
      resetn = 1'b1;
      tick(3);
      check("d1_e3_valid", 32'(kif1.key_valid), 32'h0);
      tick();
      check("d1_e4_code", 32'(kif1.key_code), 32'h3);
      check("d1_e4_valid", 32'(kif1.key_valid), 32'h1);
      tick(2);
      check("e6_valid", 32'(kif.key_valid), 32'h0);
      check("e6_db", 32'(keys_db), 32'h0);
      tick();
      check("e7_code", 32'(kif.key_code), 32'h3);
      check("e7_db", 32'(keys_db), 32'h04);
      check("e7_valid", 32'(kif.key_valid), 32'h1);
      accept();
      check("acc_valid", 32'(kif.key_valid), 32'h0);

      // 2: glitch rejection from an empty, accepted state
      settle(7'b0000000);
      accept();
      raw_keys = 7'b0000001;
      tick(3);
      raw_keys = 7'b0000000;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("gl_db", 32'(keys_db), 32'h0);
         check("gl_valid", 32'(kif.key_valid), 32'h0);
      end
      check("gl_code", 32'(kif.key_code), 32'h0);

      // 3: priority, lower key under a held higher key is silent
      settle(7'b1000000);
      check("p_code7", 32'(kif.key_code), 32'h7);
      check("p_valid7", 32'(kif.key_valid), 32'h1);
      accept();
      settle(7'b1000010);
      check("p_db", 32'(keys_db), 32'h42);
      check("p_code_hold", 32'(kif.key_code), 32'h7);
      check("p_no_valid", 32'(kif.key_valid), 32'h0);
      settle(7'b0000010);
      check("p_code2", 32'(kif.key_code), 32'h2);
      check("p_valid2", 32'(kif.key_valid), 32'h1);

      // 4: overrun
      accept();
      settle(7'b0000001);
      check("o_code1", 32'(kif.key_code), 32'h1);
      check("o_ovr0", 32'(kif.overrun), 32'h0);
      settle(7'b0010000);
      check("o_ovr1", 32'(kif.overrun), 32'h1);
      check("o_code5", 32'(kif.key_code), 32'h5);
      check("o_valid", 32'(kif.key_valid), 32'h1);
      tick();
      check("o_pulse", 32'(kif.overrun), 32'h0);

      // 5: acceptance on the same edge as a new commit
      raw_keys = 7'b1000000;
      tick(6);
      check("c_pre_code", 32'(kif.key_code), 32'h5);
      kif.key_ready = 1'b1;
      tick();
      kif.key_ready = 1'b0;
      check("c_valid", 32'(kif.key_valid), 32'h1);
      check("c_code", 32'(kif.key_code), 32'h7);
      check("c_ovr", 32'(kif.overrun), 32'h0);

      // 6: release to no key
      accept();
      settle(7'b0000100);
      check("r_code3", 32'(kif.key_code), 32'h3);
      accept();
      raw_keys = 7'b0000000;
      tick(6);
      check("r_e6_code", 32'(kif.key_code), 32'h3);
      tick();
      check("r_code0", 32'(kif.key_code), 32'h0);
      check("r_db0", 32'(keys_db), 32'h0);
      check("r_valid", 32'(kif.key_valid), 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
